// File: rtl/odd_parity_checker_serial.sv
// Serial odd-parity checker: reassembles MSB-first {d[DW-1:0], p} codewords,
// flags parity errors and keeps a saturating error count.
module odd_parity_checker_serial #(
   parameter int unsigned DW   = 4,
   parameter int unsigned CNTW = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            sin,
   input  logic            bit_valid,
   input  logic            sof,
   output logic [DW-1:0]   o,
   output logic            err,
   output logic            out_valid,
   output logic            frm_err,
   output logic [CNTW-1:0] err_cnt
);

   localparam int unsigned CW = $clog2(DW + 2);

   typedef enum logic {IDLE, RECV} state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic [DW-1:0]   sr_q;
   logic            acc_q;
   logic            done_q;
   logic [DW-1:0]   data_q;
   logic            perr_q;
   logic [DW-1:0]   o_q;
   logic            err_q;
   logic            out_valid_q;
   logic            frm_err_q;
   logic [CNTW-1:0] err_cnt_q;

   logic [DW-1:0]   sr_d;
   logic            acc_d;
   logic            last_bit;

   always_comb begin
      sr_d     = {sr_q[DW-2:0], sin};
      acc_d    = acc_q ^ sin;
      last_bit = (cnt_q == CW'(DW));
   end

   // Completed codewords are staged in data_q/perr_q so the result appears one
   // edge after the parity bit, even when a new frame starts on that edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         sr_q        <= '0;
         acc_q       <= 1'b0;
         done_q      <= 1'b0;
         data_q      <= '0;
         perr_q      <= 1'b0;
         o_q         <= '0;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
         frm_err_q   <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         out_valid_q <= done_q;
         frm_err_q   <= 1'b0;
         done_q      <= 1'b0;
         if (done_q) begin
            o_q   <= data_q;
            err_q <= perr_q;
            if (perr_q && (err_cnt_q != '1))
               err_cnt_q <= err_cnt_q + CNTW'(1);
         end
         if (bit_valid) begin
            unique case (state_q)
               IDLE: begin
                  if (sof) begin
                     sr_q    <= sr_d;
                     acc_q   <= sin;
                     cnt_q   <= CW'(1);
                     state_q <= RECV;
                  end
               end
               RECV: begin
                  if (sof) begin
                     frm_err_q <= 1'b1;
                     sr_q      <= sr_d;
                     acc_q     <= sin;
                     cnt_q     <= CW'(1);
                  end else if (last_bit) begin
                     done_q  <= 1'b1;
                     data_q  <= sr_q;
                     perr_q  <= ~acc_d;
                     cnt_q   <= '0;
                     state_q <= IDLE;
                  end else begin
                     sr_q  <= sr_d;
                     acc_q <= acc_d;
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign o         = o_q;
   assign err       = err_q;
   assign out_valid = out_valid_q;
   assign frm_err   = frm_err_q;
   assign err_cnt   = err_cnt_q;

endmodule
